touch_scan_ctrl: RTL

Fabric-side 4-wire resistive touch-panel scanner for the touchscreen subsystem, next to the MSS ADC and GPIO. Drives X/Y plate excitation and waits a programmable settle time. Requests ADC conversions over a req/ack handshake, averages 2^AVG_LOG2 samples per axis, and publishes a coordinate only if the pen stayed down for the whole scan. Supports single-shot and continuous modes.

---
 rtl/touch_scan_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/touch_scan_ctrl.sv
// 4-wire resistive touch-panel scanner: plate excitation, settle timing, ADC req/ack
// sampling with per-axis averaging, and pen-lift qualification of every coordinate.
module touch_scan_ctrl #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE_W = 10
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                enable,
  input  logic                continuous,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                pen_down_n,
  output logic                drive_x,
  output logic                drive_y,
  output logic                adc_ch,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic [ADC_W-1:0]    x_out,
  output logic [ADC_W-1:0]    y_out,
  output logic                coord_valid,
  output logic                pen_up,
  output logic                busy,
  output logic [2:0]          dbg_state_o
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE_X = 3'd1,
    S_SAMPLE_X = 3'd2,
    S_SETTLE_Y = 3'd3,
    S_SAMPLE_Y = 3'd4,
    S_CHECK    = 3'd5,
    S_PUBLISH  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]     smp_q, smp_d;
  logic                 req_q, req_d;
  logic                 lift_q, lift_d;
  logic [ACC_W-1:0]     acc_x_q, acc_x_d;
  logic [ACC_W-1:0]     acc_y_q, acc_y_d;
  logic [ADC_W-1:0]     x_q, x_d;
  logic [ADC_W-1:0]     y_q, y_d;
  logic                 cv_q, cv_d;

  logic                 pen_s1_q, pen_s2_q;
  logic                 pen_prev_q;
  logic                 pen_up_q;
  logic                 pen_dn;
  logic                 enter_x;
  logic                 scanning;
  logic [SETTLE_W-1:0]  settle_load;

  // Synchroniser flops reset to "pen up" so a reset never looks like a touch.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pen_s1_q   <= 1'b1;
      pen_s2_q   <= 1'b1;
      pen_prev_q <= 1'b0;
      pen_up_q   <= 1'b0;
    end else begin
      pen_s1_q   <= pen_down_n;
      pen_s2_q   <= pen_s1_q;
      pen_prev_q <= pen_dn;
      pen_up_q   <= enable & pen_prev_q & ~pen_dn;
    end
  end

  assign pen_dn      = ~pen_s2_q;
  assign settle_load = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  assign scanning    = (state_q == S_SETTLE_X) || (state_q == S_SAMPLE_X) ||
                       (state_q == S_SETTLE_Y) || (state_q == S_SAMPLE_Y);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    smp_d    = smp_q;
    req_d    = req_q;
    lift_d   = lift_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    x_d      = x_q;
    y_d      = y_q;
    cv_d     = 1'b0;
    enter_x  = 1'b0;

    if (scanning && !pen_dn) begin
      lift_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && pen_dn && (continuous || start)) begin
          state_d = S_SETTLE_X;
          enter_x = 1'b1;
        end
      end

      S_SETTLE_X, S_SETTLE_Y: begin
        settle_d = settle_q - SETTLE_W'(1);
        if (!enable) begin
          state_d = S_IDLE;
        end else if (settle_q == SETTLE_W'(1)) begin
          state_d = (state_q == S_SETTLE_X) ? S_SAMPLE_X : S_SAMPLE_Y;
          req_d   = 1'b1;
          smp_d   = '0;
        end
      end

      // req is held until ack even while disabled, so the ADC never sees a
      // withdrawn request; the sample taken during an abort is discarded.
      S_SAMPLE_X, S_SAMPLE_Y: begin
        if (req_q) begin
          if (adc_ack) begin
            req_d = 1'b0;
            if (!enable) begin
              state_d = S_IDLE;
            end else begin
              smp_d = smp_q + CNT_W'(1);
              if (state_q == S_SAMPLE_X) begin
                acc_x_d = acc_x_q + ACC_W'(adc_data);
              end else begin
                acc_y_d = acc_y_q + ACC_W'(adc_data);
              end
            end
          end
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (smp_q == N_SAMPLES) begin
          if (state_q == S_SAMPLE_X) begin
            state_d  = S_SETTLE_Y;
            settle_d = settle_load;
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          req_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (!enable || lift_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PUBLISH;
          x_d     = ADC_W'(acc_x_q >> AVG_LOG2);
          y_d     = ADC_W'(acc_y_q >> AVG_LOG2);
          cv_d    = 1'b1;
        end
      end

      S_PUBLISH: begin
        if (continuous && enable && pen_dn) begin
          state_d = S_SETTLE_X;
          enter_x = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (enter_x) begin
      settle_d = settle_load;
      lift_d   = 1'b0;
      acc_x_d  = '0;
      acc_y_d  = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      smp_q    <= '0;
      req_q    <= 1'b0;
      lift_q   <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      smp_q    <= smp_d;
      req_q    <= req_d;
      lift_q   <= lift_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cv_q     <= cv_d;
    end
  end

  assign drive_x     = (state_q == S_SETTLE_X) || (state_q == S_SAMPLE_X);
  assign drive_y     = (state_q == S_SETTLE_Y) || (state_q == S_SAMPLE_Y);
  assign adc_ch      = drive_y;
  assign adc_req     = req_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign coord_valid = cv_q;
  assign pen_up      = pen_up_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
